// File: rtl/fifo_burst_writer.sv
// Burst writer: moves BURST_LEN source words into a FIFO write port through a one-word
// output register with Full backpressure. Optional macro FIFO_WR_STATS_EN adds Stall_cnt.
module fifo_burst_writer #(
   parameter int unsigned SIZE      = 8,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_SIZE  = 3
) (
   input  logic            Wr_clk,
   input  logic            RST,
   input  logic            Start,
   input  logic [SIZE-1:0] Src_Data,
   input  logic            Src_Valid,
   output logic            Src_Ready,
   input  logic            Full,
   output logic [SIZE-1:0] Fifo_Data,
   output logic            Fifo_Wr_En,
   output logic            Busy,
   output logic            Done
`ifdef FIFO_WR_STATS_EN
   ,
   output logic [15:0]     Stall_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [CNT_SIZE-1:0] rem_q, rem_d;
   logic [SIZE-1:0]     data_q, data_d;
   logic                wr_en_q, wr_en_d;
   logic                handshake;
   logic                accept;

   always_ff @(posedge Wr_clk) begin
      if (RST) begin
         state_q <= StIdle;
         rem_q   <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      data_d    = data_q;
      wr_en_d   = wr_en_q;
      // The output register can take a new word when empty or when the FIFO drains it now.
      Src_Ready = (state_q == StXfer) && (!wr_en_q || !Full);
      handshake = Src_Ready && Src_Valid;
      accept    = wr_en_q && !Full;

      if (handshake) begin
         data_d  = Src_Data;
         wr_en_d = 1'b1;
      end else if (accept) begin
         wr_en_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StXfer;
               rem_d   = CNT_SIZE'(BURST_LEN);
            end
         end
         StXfer: begin
            if (handshake) begin
               rem_d = rem_q - CNT_SIZE'(1);
               if (rem_q == CNT_SIZE'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (accept) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign Fifo_Data  = data_q;
   assign Fifo_Wr_En = wr_en_q;
   assign Busy       = (state_q != StIdle);
   assign Done       = (state_q == StDone);

`ifdef FIFO_WR_STATS_EN
   logic [15:0] stall_q;

   // Saturating count of edges where a pending write is refused by the FIFO.
   always_ff @(posedge Wr_clk) begin
      if (RST) begin
         stall_q <= '0;
      end else if (wr_en_q && Full && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign Stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: vector table, hand-written corner sequences and
// randomized bursts compared against a word-order reference model.
module tb_fifo_burst_writer;

   localparam int unsigned BL = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, src_valid, full;
   logic [7:0] src_data;
   logic       src_ready, fifo_wr_en, busy, done;
   logic [7:0] fifo_data;

   logic       start1, valid1;
   logic [7:0] data1;
   logic       ready1, wr1, busy1, done1;
   logic [7:0] fdata1;

`ifdef FIFO_WR_STATS_EN
   logic [15:0] stall_cnt, stall_cnt1;
   int          stall_exp = 0;
`endif

   fifo_burst_writer #(.SIZE(8), .BURST_LEN(BL), .CNT_SIZE(3)) u_dut (
      .Wr_clk     (clk),
      .RST        (rst),
      .Start      (start),
      .Src_Data   (src_data),
      .Src_Valid  (src_valid),
      .Src_Ready  (src_ready),
      .Full       (full),
      .Fifo_Data  (fifo_data),
      .Fifo_Wr_En (fifo_wr_en),
      .Busy       (busy),
      .Done       (done)
`ifdef FIFO_WR_STATS_EN
      ,
      .Stall_cnt  (stall_cnt)
`endif
   );

   fifo_burst_writer #(.SIZE(8), .BURST_LEN(1), .CNT_SIZE(1)) u_one (
      .Wr_clk     (clk),
      .RST        (rst),
      .Start      (start1),
      .Src_Data   (data1),
      .Src_Valid  (valid1),
      .Src_Ready  (ready1),
      .Full       (full),
      .Fifo_Data  (fdata1),
      .Fifo_Wr_En (wr1),
      .Busy       (busy1),
      .Done       (done1)
`ifdef FIFO_WR_STATS_EN
      ,
      .Stall_cnt  (stall_cnt1)
`endif
   );

   typedef struct {
      logic       rst, start, valid, full;
      logic [7:0] data;
      logic       exp_ready, exp_wr;
      logic [7:0] exp_data;
      logic       exp_busy, exp_done;
   } vec_t;

   vec_t       vecs[18];
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] got[$];
   int         done_cnt, done_at;
   logic       ready_pre;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic v, input logic f,
                               input logic [7:0] d, input logic er, input logic ew,
                               input logic [7:0] ed, input logic eb, input logic edn);
      vec_t x;
      x.rst = r; x.start = s; x.valid = v; x.full = f; x.data = d;
      x.exp_ready = er; x.exp_wr = ew; x.exp_data = ed; x.exp_busy = eb; x.exp_done = edn;
      return x;
   endfunction

   // Observe the pre-edge cycle (FIFO writes, Done), then advance one clock.
   task automatic step();
      #1;
      ready_pre = src_ready;
      if (fifo_wr_en && !full) got.push_back(fifo_data);
      if (done) begin
         done_cnt++;
         done_at = got.size();
      end
`ifdef FIFO_WR_STATS_EN
      if (rst) stall_exp = 0;
      else if (fifo_wr_en && full && stall_exp != 65535) stall_exp++;
`endif
      @(posedge clk);
      #1;
   endtask

   // One burst with random source/FIFO behaviour; the FIFO must see exactly the first BL
   // source words, in order, followed by a single Done.
   task automatic run_burst(input int p_valid, input int p_full, input int p_start,
                            input string tag);
      logic [7:0] words[8];
      int         idx;
      bit         finished;
      for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
      got.delete();
      done_cnt = 0;
      done_at  = -1;
      idx      = 0;
      finished = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         start     = (cyc == 0) || (int'($urandom_range(99)) < p_start);
         src_valid = int'($urandom_range(99)) < p_valid;
         src_data  = words[idx];
         full      = int'($urandom_range(99)) < p_full;
         step();
         if (src_valid && ready_pre) idx++;
         if (cyc > 0 && !busy) finished = 1'b1;
      end
      start = 1'b0; src_valid = 1'b0; full = 1'b0;
      chk({tag, " finished"}, 32'(finished), 32'd1);
      chk({tag, " writes"}, 32'(got.size()), 32'(BL));
      for (int i = 0; i < int'(BL); i++)
         chk($sformatf("%s word%0d", tag, i),
             (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(words[i]));
      chk({tag, " handshakes"}, 32'(idx), 32'(BL));
      chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, " done after last"}, 32'(done_at), 32'(BL));
   endtask

   initial begin
      // Basic burst, then backpressure with Start pulses mid-burst.
      vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      vecs[1]  = mk(0, 1, 1, 0, 8'h11, 0, 0, 8'h00, 1, 0);
      vecs[2]  = mk(0, 0, 1, 0, 8'h11, 1, 1, 8'h11, 1, 0);
      vecs[3]  = mk(0, 0, 1, 0, 8'h12, 1, 1, 8'h12, 1, 0);
      vecs[4]  = mk(0, 0, 1, 0, 8'h13, 1, 1, 8'h13, 1, 0);
      vecs[5]  = mk(0, 0, 1, 0, 8'h14, 1, 1, 8'h14, 1, 0);
      vecs[6]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h14, 1, 1);
      vecs[7]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h14, 0, 0);
      vecs[8]  = mk(0, 1, 1, 0, 8'h11, 0, 0, 8'h14, 1, 0);
      vecs[9]  = mk(0, 0, 1, 0, 8'h11, 1, 1, 8'h11, 1, 0);
      vecs[10] = mk(0, 0, 1, 0, 8'h12, 1, 1, 8'h12, 1, 0);
      vecs[11] = mk(0, 0, 1, 1, 8'h13, 0, 1, 8'h12, 1, 0);
      vecs[12] = mk(0, 1, 1, 1, 8'h13, 0, 1, 8'h12, 1, 0);
      vecs[13] = mk(0, 0, 1, 1, 8'h13, 0, 1, 8'h12, 1, 0);
      vecs[14] = mk(0, 0, 1, 0, 8'h13, 1, 1, 8'h13, 1, 0);
      vecs[15] = mk(0, 0, 1, 0, 8'h14, 1, 1, 8'h14, 1, 0);
      vecs[16] = mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h14, 1, 1);
      vecs[17] = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h14, 0, 0);

      rst = 1'b1; start = 1'b0; src_valid = 1'b0; full = 1'b0; src_data = 8'h00;
      start1 = 1'b0; valid1 = 1'b0; data1 = 8'h00;
      done_cnt = 0; done_at = -1;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         if (i == 8) got.delete();
         rst = vecs[i].rst; start = vecs[i].start; src_valid = vecs[i].valid;
         full = vecs[i].full; src_data = vecs[i].data;
         step();
         chk($sformatf("vec%0d ready", i), 32'(ready_pre), 32'(vecs[i].exp_ready));
         chk($sformatf("vec%0d wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].exp_wr));
         chk($sformatf("vec%0d data", i), 32'(fifo_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
`ifdef FIFO_WR_STATS_EN
         if (i == 7) chk("stall after basic", 32'(stall_cnt), 32'd0);
`endif
      end
      chk("backpressure writes", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("backpressure word%0d", i),
             (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'h11 + 32'(i));
`ifdef FIFO_WR_STATS_EN
      chk("stall after backpressure", 32'(stall_cnt), 32'd3);
`endif

      // Gapped source: valid toggles every cycle.
      got.delete(); done_cnt = 0; done_at = -1;
      begin
         int idx = 0;
         start = 1'b1; src_valid = 1'b0; full = 1'b0;
         step();
         start = 1'b0;
         for (int c = 0; c < 16; c++) begin
            src_valid = (c % 2 == 0);
            src_data  = 8'(8'h31 + idx);
            step();
            if (src_valid && ready_pre) idx++;
         end
         src_valid = 1'b0;
      end
      chk("gapped writes", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("gapped word%0d", i),
             (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'h31 + 32'(i));
      chk("gapped done pulses", 32'(done_cnt), 32'd1);
      chk("gapped done after 4th", 32'(done_at), 32'd4);

      // Reset mid-burst while the FIFO is full.
      got.delete();
      start = 1'b1; src_valid = 1'b1; src_data = 8'h21; full = 1'b0;
      step();
      start = 1'b0;
      step();
      src_data = 8'h22;
      step();
      full = 1'b1; src_data = 8'h23;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; full = 1'b0; src_valid = 1'b0;
      #1;
      chk("reset wr_en", 32'(fifo_wr_en), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset data", 32'(fifo_data), 32'd0);
      chk("reset ready", 32'(src_ready), 32'd0);
      chk("reset partial writes", 32'(got.size()), 32'd1);
`ifdef FIFO_WR_STATS_EN
      chk("reset stall", 32'(stall_cnt), 32'd0);
`endif
      run_burst(100, 0, 0, "post_reset");

      // Single-word burst instance.
      start1 = 1'b1; valid1 = 1'b1; data1 = 8'hA5; full = 1'b0;
      step();
      start1 = 1'b0;
      #1;
      chk("len1 xfer busy", 32'(busy1), 32'd1);
      chk("len1 xfer ready", 32'(ready1), 32'd1);
      chk("len1 xfer wr_en", 32'(wr1), 32'd0);
      step();
      chk("len1 drain wr_en", 32'(wr1), 32'd1);
      chk("len1 drain data", 32'(fdata1), 32'hA5);
      chk("len1 drain ready", 32'(ready1), 32'd0);
      chk("len1 drain done", 32'(done1), 32'd0);
      step();
      chk("len1 done wr_en", 32'(wr1), 32'd0);
      chk("len1 done pulse", 32'(done1), 32'd1);
      chk("len1 done busy", 32'(busy1), 32'd1);
      step();
      chk("len1 idle busy", 32'(busy1), 32'd0);
      chk("len1 idle done", 32'(done1), 32'd0);
      valid1 = 1'b0;

      // Randomized bursts.
      for (int b = 0; b < 8; b++) run_burst(60, 30, 10, $sformatf("rand%0d", b));
`ifdef FIFO_WR_STATS_EN
      chk("random stall count", 32'(stall_cnt), 32'(stall_exp));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 Parameter SIZE, default 8, data word width in bits; SHALL match the FIFO data width.
REQ-002 Parameter BURST_LEN, default 4, words per burst; SHALL be at least 1.
REQ-003 Parameter CNT_SIZE, default 3, remaining-counter width; SHALL satisfy 2^CNT_SIZE > BURST_LEN.
REQ-004 Wr_clk  in  1  clock; the FIFO write clock, all logic on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 Start  in  1  request one burst; sampled only in IDLE.
REQ-007 Src_Data  in  SIZE  source word.
REQ-008 Src_Valid  in  1  source word available.
REQ-009 Src_Ready  out  1  block accepts Src_Data this cycle.
REQ-010 Full  in  1  FIFO full flag; a write with Full=1 is discarded by the FIFO.
REQ-011 Fifo_Data  out  SIZE  word presented to the FIFO Data_in.
REQ-012 Fifo_Wr_En  out  1  write request to the FIFO Wr_En_in; registered.
REQ-013 Busy  out  1  high in every state except IDLE.
REQ-014 Done  out  1  one-cycle pulse when the last burst word is written into the FIFO.

Function
REQ-015 States: IDLE, XFER, DRAIN, DONE; the state register is the only source of Busy and Done.
- IDLE to XFER: on Start=1; load remaining counter with BURST_LEN.
- XFER to DRAIN: on the source handshake that takes remaining from 1 to 0.
- DRAIN to DONE: when the output register is accepted.
- DONE to IDLE: unconditionally after one cycle.
REQ-016 Source handshake SHALL occur when Src_Valid=1 and Src_Ready=1; each handshake decrements the remaining counter by 1.
REQ-017 Src_Ready SHALL equal (state==XFER) AND (Fifo_Wr_En==0 OR Full==0); the output is combinational.
REQ-018 On a source handshake, Src_Data SHALL be registered into Fifo_Data and Fifo_Wr_En SHALL be set to 1 on the same edge; latency from source to FIFO port is 1 cycle.
REQ-019 FIFO acceptance is Fifo_Wr_En=1 AND Full=0 at an edge; with no new handshake on that edge, Fifo_Wr_En SHALL clear to 0.
REQ-020 While Fifo_Wr_En=1 and Full=1, Fifo_Data and Fifo_Wr_En SHALL hold unchanged; no word is lost or duplicated.
REQ-021 Acceptance and a new handshake on the same edge SHALL replace Fifo_Data, keep Fifo_Wr_En=1, and sustain one word per cycle.
REQ-022 Start SHALL be ignored outside IDLE.
REQ-023 Start and Src_Valid in the same IDLE cycle SHALL NOT handshake; the first handshake is possible on the next cycle.
REQ-024 With BURST_LEN=1, a single handshake SHALL move the state from XFER to DRAIN.
REQ-025 Done SHALL be 1 exactly in state DONE; Busy=0 and Src_Ready=0 in IDLE.
REQ-026 Fifo_Data SHALL change only on a handshake; it is not cleared on acceptance.

Reset
REQ-027 RST=1 at an edge SHALL force IDLE, remaining=0, Fifo_Wr_En=0, Fifo_Data=0, Busy=0, Done=0; this overrides all other inputs.
REQ-028 RST during XFER or DRAIN SHALL abort the burst and discard any held word; no FIFO write occurs on the cycle after reset.

Configuration
REQ-029 Macro FIFO_WR_STATS_EN when defined SHALL add output Stall_cnt, 16 bits.
- Stall_cnt increments on every edge with Fifo_Wr_En=1 and Full=1.
- It saturates at 16'hFFFF, clears only on RST, and is not cleared by Start.
REQ-030 Without FIFO_WR_STATS_EN, the Stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Basic burst: Full=0, Src_Valid held 1, Start pulse with data 0x11..0x14 -> Fifo_Wr_En high for 4 consecutive cycles starting 2 cycles after Start, Fifo_Data 0x11,0x12,0x13,0x14, Done pulses once, Busy drops the next cycle.
REQ-032 Backpressure: Full=1 for 3 cycles while Fifo_Data=0x12 is presented -> 0x12 held with Src_Ready=0, no handshake; after Full=0 the order is 0x12,0x13,0x14 with no duplicates; with FIFO_WR_STATS_EN, Stall_cnt=3.
REQ-033 Gapped source: Src_Valid toggling 1,0,1,0 -> exactly 4 FIFO writes; Done only after the 4th accepted write.
REQ-034 Start ignored: Start pulsed again mid-burst -> still exactly 4 words total; a second burst runs only when Start is given in IDLE.
REQ-035 Reset mid-burst: RST after 2 handshakes while Full=1 -> next cycle Fifo_Wr_En=0, Busy=0, Stall_cnt=0; a new Start then gives a full 4-word burst.
REQ-036 BURST_LEN=1: Start plus one word 0xA5 -> one write of 0xA5, state sequence XFER, DRAIN, DONE, IDLE.
